// File: rtl/noc_sched_pkg.sv
// Shared types and default sizing for the NoC output-port scheduler.
package noc_sched_pkg;

  localparam int unsigned DEF_PORTS    = 5;
  localparam int unsigned DEF_CHANNELS = 4;
  localparam int unsigned DEF_NUM_REQ  = DEF_PORTS * DEF_CHANNELS;
  localparam int unsigned DEF_VID_BITS = $clog2(DEF_NUM_REQ);

  // Requester (port/VC) index at the default router size
  typedef logic [DEF_VID_BITS-1:0] vid_t;

  typedef enum logic {
    StIdle,
    StLock
  } sched_state_e;

endpackage

// File: rtl/arrival_fifo.sv
// Arrival-order queue of requester indices: many pushes per cycle (ascending index), one pop.
// Each index is queued at most once (tracked by r_queued), so a depth of NUM_REQ never overflows.
module arrival_fifo
  import noc_sched_pkg::*;
#(
  parameter int unsigned NUM_REQ  = DEF_NUM_REQ,
  parameter int unsigned VID_BITS = $clog2(NUM_REQ)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_REQ-1:0]  i_req,
  input  logic                i_owner_vld,
  input  logic [VID_BITS-1:0] i_owner,
  input  logic                i_pop,
  output logic [VID_BITS-1:0] o_head,
  output logic                o_empty
);

  localparam int unsigned CNT_BITS = $clog2(NUM_REQ + 1);

  logic [VID_BITS-1:0] r_mem [NUM_REQ];
  logic [VID_BITS-1:0] w_mem_d [NUM_REQ];
  logic [VID_BITS-1:0] r_head, w_head_d;
  logic [VID_BITS-1:0] r_tail, w_tail_d;
  logic [CNT_BITS-1:0] r_count, w_count_d, w_npush;
  logic [NUM_REQ-1:0]  r_queued, w_queued_d;
  logic [NUM_REQ-1:0]  w_owner_mask, w_arrive;

  assign o_head  = r_mem[r_head];
  assign o_empty = (r_count == '0);

  // New arrivals: requesting, not already queued, and not the current lock owner
  always_comb begin
    w_owner_mask = '0;
    if (i_owner_vld) w_owner_mask[i_owner] = 1'b1;
    w_arrive = i_req & ~r_queued & ~w_owner_mask;
  end

  // Push arrivals in ascending index order at the tail; pop one entry from the head
  always_comb begin
    w_mem_d    = r_mem;
    w_tail_d   = r_tail;
    w_npush    = '0;
    w_head_d   = r_head;
    w_queued_d = r_queued | w_arrive;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_arrive[i]) begin
        w_mem_d[w_tail_d] = VID_BITS'(i);
        w_tail_d = (w_tail_d == VID_BITS'(NUM_REQ - 1)) ? '0 : w_tail_d + 1'b1;
        w_npush  = w_npush + 1'b1;
      end
    end
    if (i_pop) begin
      w_head_d = (r_head == VID_BITS'(NUM_REQ - 1)) ? '0 : r_head + 1'b1;
      w_queued_d[r_mem[r_head]] = 1'b0;
    end
    w_count_d = r_count + w_npush - CNT_BITS'(i_pop);
  end

  // Pointer, occupancy and bitmap state
  always_ff @(posedge clk) begin
    if (rst) begin
      r_head   <= '0;
      r_tail   <= '0;
      r_count  <= '0;
      r_queued <= '0;
    end else begin
      r_head   <= w_head_d;
      r_tail   <= w_tail_d;
      r_count  <= w_count_d;
      r_queued <= w_queued_d;
    end
  end

  // Entry storage; contents are qualified by r_count so no reset is needed
  always_ff @(posedge clk) begin
    r_mem <= w_mem_d;
  end

endmodule

// File: rtl/wormhole_out_sched.sv
// Per-output-port wormhole scheduler: FCFS arbitration, head-to-tail lock, credit gating.
// Optional idle-lock timeout with o_lock_abort is built when WORMHOLE_LOCK_TIMEOUT_EN is defined.
module wormhole_out_sched
  import noc_sched_pkg::*;
#(
  parameter int unsigned PORTS        = DEF_PORTS,
  parameter int unsigned CHANNELS     = DEF_CHANNELS,
  parameter int unsigned CREDITS      = 4,
  parameter int unsigned LOCK_TIMEOUT = 64,
  localparam int unsigned NUM_REQ     = PORTS * CHANNELS,
  localparam int unsigned VID_BITS    = $clog2(NUM_REQ),
  localparam int unsigned CR_BITS     = $clog2(CREDITS + 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_REQ-1:0]  i_req,
  input  logic [NUM_REQ-1:0]  i_req_tail,
  input  logic                i_credit_ret,
  output logic [NUM_REQ-1:0]  o_gnt,
  output logic [VID_BITS-1:0] o_gnt_idx,
  output logic                o_busy,
  output logic [CR_BITS-1:0]  o_credit_cnt,
  output logic                o_credit_ovf
`ifdef WORMHOLE_LOCK_TIMEOUT_EN
  ,
  output logic                o_lock_abort
`endif
);

  sched_state_e        r_state, w_state_d;
  logic [VID_BITS-1:0] r_owner, w_owner_d;
  logic [CR_BITS-1:0]  r_credit, w_credit_d;
  logic                r_ovf, w_ovf_d;
  logic                w_pop, w_empty, w_xfer;
  logic [VID_BITS-1:0] w_head;

  arrival_fifo #(
    .NUM_REQ  (NUM_REQ),
    .VID_BITS (VID_BITS)
  ) u_arrival_fifo (
    .clk         (clk),
    .rst         (rst),
    .i_req       (i_req),
    .i_owner_vld (r_state == StLock),
    .i_owner     (r_owner),
    .i_pop       (w_pop),
    .o_head      (w_head),
    .o_empty     (w_empty)
  );

  // A flit moves only when the owner offers one and downstream has room
  assign w_xfer       = (r_state == StLock) && i_req[r_owner] && (r_credit != '0);
  assign o_busy       = (r_state == StLock);
  assign o_gnt_idx    = r_owner;
  assign o_credit_cnt = r_credit;
  assign o_credit_ovf = r_ovf;

`ifdef WORMHOLE_LOCK_TIMEOUT_EN
  localparam int unsigned TO_BITS = $clog2(LOCK_TIMEOUT + 1);
  logic [TO_BITS-1:0] r_to_cnt;
  logic               w_to_hit;

  assign w_to_hit     = (r_state == StLock) && (r_to_cnt == TO_BITS'(LOCK_TIMEOUT));
  assign o_lock_abort = w_to_hit;

  // Count locked cycles where the owner offers nothing; any transfer restarts the count
  always_ff @(posedge clk) begin
    if (rst || (r_state != StLock) || w_xfer || w_to_hit) begin
      r_to_cnt <= '0;
    end else if (!i_req[r_owner]) begin
      r_to_cnt <= r_to_cnt + 1'b1;
    end
  end
`endif

  // One-hot grant to the owner on a transfer cycle
  always_comb begin
    o_gnt = '0;
    if (w_xfer) o_gnt[r_owner] = 1'b1;
  end

  // Next state: pop the queue head in IDLE (stale heads are dropped), hold the lock until tail
  always_comb begin
    w_state_d = r_state;
    w_owner_d = r_owner;
    w_pop     = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (!w_empty) begin
          w_pop = 1'b1;
          if (i_req[w_head]) begin
            w_state_d = StLock;
            w_owner_d = w_head;
          end
        end
      end
      StLock: begin
        if (w_xfer && i_req_tail[r_owner]) w_state_d = StIdle;
`ifdef WORMHOLE_LOCK_TIMEOUT_EN
        if (w_to_hit) w_state_d = StIdle;
`endif
      end
    endcase
  end

  // Credit next state: a transfer and a return in the same cycle cancel out
  always_comb begin
    w_credit_d = r_credit;
    w_ovf_d    = r_ovf;
    if (w_xfer && !i_credit_ret) begin
      w_credit_d = r_credit - 1'b1;
    end else if (!w_xfer && i_credit_ret) begin
      if (r_credit == CR_BITS'(CREDITS)) w_ovf_d = 1'b1;
      else w_credit_d = r_credit + 1'b1;
    end
  end

  // FSM, owner and credit registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= StIdle;
      r_owner  <= '0;
      r_credit <= CR_BITS'(CREDITS);
      r_ovf    <= 1'b0;
    end else begin
      r_state  <= w_state_d;
      r_owner  <= w_owner_d;
      r_credit <= w_credit_d;
      r_ovf    <= w_ovf_d;
    end
  end

endmodule

// File: tb/tb_wormhole_out_sched.sv
// Directed bench for wormhole_out_sched (default sizing: 20 requesters, 4 credits).
module tb_wormhole_out_sched;

  localparam int N = 20;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  req, req_tail;
  logic          credit_ret;
  logic [N-1:0]  gnt;
  logic [4:0]    gnt_idx;
  logic          busy;
  logic [2:0]    credit_cnt;
  logic          credit_ovf;
`ifdef WORMHOLE_LOCK_TIMEOUT_EN
  logic          lock_abort;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  wormhole_out_sched dut (
    .clk          (clk),
    .rst          (rst),
    .i_req        (req),
    .i_req_tail   (req_tail),
    .i_credit_ret (credit_ret),
    .o_gnt        (gnt),
    .o_gnt_idx    (gnt_idx),
    .o_busy       (busy),
    .o_credit_cnt (credit_cnt),
    .o_credit_ovf (credit_ovf)
`ifdef WORMHOLE_LOCK_TIMEOUT_EN
    ,
    .o_lock_abort (lock_abort)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [N-1:0] bit_of(input int i);
    logic [N-1:0] v;
    v = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  // Advance to just after the next rising edge
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; req = '0; req_tail = '0; credit_ret = 1'b0;
    next_cycle();
    rst = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++; if (gnt !== '0) begin n_fail++; $display("FAIL reset_gnt: got %h want 0", gnt); end
    n_checks++; if (gnt_idx !== 5'd0) begin n_fail++; $display("FAIL reset_gnt_idx: got %0d want 0", gnt_idx); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_checks++; if (credit_cnt !== 3'd4) begin n_fail++; $display("FAIL reset_credit: got %0d want 4", credit_cnt); end
    n_checks++; if (credit_ovf !== 1'b0) begin n_fail++; $display("FAIL reset_ovf: got %b want 0", credit_ovf); end
  endtask

  // 3-flit packet from requester 3: grants in cycles 2..4, credits 4 -> 1
  task automatic test_single_packet();
    int exp_cr [6] = '{4, 4, 4, 3, 2, 1};
    logic [N-1:0] eg;
    do_reset();
    for (int c = 0; c < 6; c++) begin
      req      = (c < 5) ? bit_of(3) : '0;
      req_tail = (c == 4) ? bit_of(3) : '0;
      #1;
      eg = (c >= 2 && c <= 4) ? bit_of(3) : '0;
      n_checks++; if (gnt !== eg) begin n_fail++; $display("FAIL single_gnt c%0d: got %h want %h", c, gnt, eg); end
      n_checks++; if (busy !== (c >= 2 && c <= 4)) begin n_fail++; $display("FAIL single_busy c%0d: got %b", c, busy); end
      n_checks++;
      if (credit_cnt !== 3'(exp_cr[c])) begin
        n_fail++; $display("FAIL single_credit c%0d: got %0d want %0d", c, credit_cnt, exp_cr[c]);
      end
      if (c >= 2 && c <= 4) begin
        n_checks++; if (gnt_idx !== 5'd3) begin n_fail++; $display("FAIL single_idx c%0d: got %0d want 3", c, gnt_idx); end
      end
      next_cycle();
    end
  endtask

  // 7 arrives first, then 2 and 9 together: grants must come 7, 2, 9
  task automatic test_fcfs();
    logic [N-1:0] rv;
    int got [3];
    int n_got;
    int idx;
    do_reset();
    rv = '0; n_got = 0;
    for (int c = 0; c < 20; c++) begin
      if (c == 0) rv = bit_of(7);
      if (c == 1) rv = rv | bit_of(2) | bit_of(9);
      req = rv; req_tail = rv; credit_ret = 1'b0;
      #1;
      if (gnt != '0) begin
        idx = 0;
        for (int i = 0; i < N; i++) if (gnt[i]) idx = i;
        if (n_got < 3) got[n_got] = idx;
        n_got++;
        rv[idx] = 1'b0;
        credit_ret = 1'b1;
      end
      next_cycle();
    end
    credit_ret = 1'b0; req = '0; req_tail = '0;
    n_checks++; if (n_got !== 3) begin n_fail++; $display("FAIL fcfs_count: got %0d want 3", n_got); end
    n_checks++; if (got[0] !== 7) begin n_fail++; $display("FAIL fcfs_first: got %0d want 7", got[0]); end
    n_checks++; if (got[1] !== 2) begin n_fail++; $display("FAIL fcfs_second: got %0d want 2", got[1]); end
    n_checks++; if (got[2] !== 9) begin n_fail++; $display("FAIL fcfs_third: got %0d want 9", got[2]); end
    n_checks++; if (credit_cnt !== 3'd4) begin n_fail++; $display("FAIL fcfs_credit: got %0d want 4", credit_cnt); end
  endtask

  // 6-flit packet with 4 credits: stall after 4, two returns release the last 2
  task automatic test_credit_stall();
    int sent;
    do_reset();
    sent = 0;
    for (int c = 0; c < 12; c++) begin
      req = bit_of(0); req_tail = (sent == 5) ? bit_of(0) : '0;
      #1;
      if (credit_cnt == 3'd0) begin
        n_checks++; if (gnt !== '0) begin n_fail++; $display("FAIL stall_zero_credit c%0d: got %h want 0", c, gnt); end
      end
      if (gnt[0]) sent++;
      next_cycle();
    end
    n_checks++; if (sent !== 4) begin n_fail++; $display("FAIL stall_sent: got %0d want 4", sent); end
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL stall_busy: got %b want 1", busy); end
    n_checks++; if (credit_cnt !== 3'd0) begin n_fail++; $display("FAIL stall_credit: got %0d want 0", credit_cnt); end
    for (int c = 0; c < 6; c++) begin
      req = (sent < 6) ? bit_of(0) : '0;
      req_tail = (sent == 5) ? bit_of(0) : '0;
      credit_ret = (c == 0 || c == 2);
      #1;
      if (gnt[0]) sent++;
      next_cycle();
    end
    credit_ret = 1'b0; req = '0; req_tail = '0;
    n_checks++; if (sent !== 6) begin n_fail++; $display("FAIL resume_sent: got %0d want 6", sent); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL resume_busy: got %b want 0", busy); end
    n_checks++; if (credit_cnt !== 3'd0) begin n_fail++; $display("FAIL resume_credit: got %0d want 0", credit_cnt); end
  endtask

  // Transfer + return cancel; return at full credit saturates and sets sticky overflow
  task automatic test_simultaneous();
    do_reset();
    req = bit_of(4); req_tail = '0;
    next_cycle(); next_cycle();
    #1;
    n_checks++; if (gnt !== bit_of(4)) begin n_fail++; $display("FAIL simul_gnt: got %h want %h", gnt, bit_of(4)); end
    credit_ret = 1'b1;
    next_cycle();
    n_checks++; if (credit_cnt !== 3'd4) begin n_fail++; $display("FAIL simul_credit: got %0d want 4", credit_cnt); end
    n_checks++; if (credit_ovf !== 1'b0) begin n_fail++; $display("FAIL simul_ovf: got %b want 0", credit_ovf); end
    credit_ret = 1'b0; req_tail = bit_of(4);
    next_cycle();
    n_checks++; if (credit_cnt !== 3'd3) begin n_fail++; $display("FAIL tail_credit: got %0d want 3", credit_cnt); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL tail_busy: got %b want 0", busy); end
    req = '0; req_tail = '0; credit_ret = 1'b1;
    next_cycle();
    n_checks++; if (credit_cnt !== 3'd4) begin n_fail++; $display("FAIL ret_credit: got %0d want 4", credit_cnt); end
    n_checks++; if (credit_ovf !== 1'b0) begin n_fail++; $display("FAIL ret_ovf: got %b want 0", credit_ovf); end
    next_cycle();
    n_checks++; if (credit_cnt !== 3'd4) begin n_fail++; $display("FAIL ovf_credit: got %0d want 4", credit_cnt); end
    n_checks++; if (credit_ovf !== 1'b1) begin n_fail++; $display("FAIL ovf_set: got %b want 1", credit_ovf); end
    credit_ret = 1'b0;
    next_cycle();
    n_checks++; if (credit_ovf !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky: got %b want 1", credit_ovf); end
  endtask

  // Requester 5 pulses while 1 owns the lock; its stale entry is dropped, 8 is granted next
  task automatic test_stale_entry();
    logic [N-1:0] rq [9];
    logic [N-1:0] tl [9];
    logic [N-1:0] eg [9];
    rq[0] = bit_of(1); tl[0] = '0; eg[0] = '0;
    rq[1] = bit_of(1); tl[1] = '0; eg[1] = '0;
    rq[2] = bit_of(1) | bit_of(5); tl[2] = '0; eg[2] = bit_of(1);
    rq[3] = bit_of(1) | bit_of(8); tl[3] = '0; eg[3] = bit_of(1);
    rq[4] = bit_of(1) | bit_of(8); tl[4] = bit_of(1); eg[4] = bit_of(1);
    rq[5] = bit_of(8); tl[5] = bit_of(8); eg[5] = '0;
    rq[6] = bit_of(8); tl[6] = bit_of(8); eg[6] = '0;
    rq[7] = bit_of(8); tl[7] = bit_of(8); eg[7] = bit_of(8);
    rq[8] = '0; tl[8] = '0; eg[8] = '0;
    do_reset();
    for (int c = 0; c < 9; c++) begin
      req = rq[c]; req_tail = tl[c];
      #1;
      n_checks++; if (gnt !== eg[c]) begin n_fail++; $display("FAIL stale_gnt c%0d: got %h want %h", c, gnt, eg[c]); end
      next_cycle();
    end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL stale_busy: got %b want 0", busy); end
  endtask

  // Reset during flit 2 of 4: lock, queue and credits restart; 2 then 6 re-arrive fresh
  task automatic test_reset_mid_packet();
    do_reset();
    req = bit_of(2) | bit_of(6); req_tail = '0;
    next_cycle(); next_cycle();
    #1;
    n_checks++; if (gnt !== bit_of(2)) begin n_fail++; $display("FAIL mid_flit1: got %h want %h", gnt, bit_of(2)); end
    next_cycle();
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
    #1;
    n_checks++; if (gnt !== '0) begin n_fail++; $display("FAIL mid_rst_gnt: got %h want 0", gnt); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL mid_rst_busy: got %b want 0", busy); end
    n_checks++; if (credit_cnt !== 3'd4) begin n_fail++; $display("FAIL mid_rst_credit: got %0d want 4", credit_cnt); end
    next_cycle();
    #1;
    n_checks++; if (gnt !== '0) begin n_fail++; $display("FAIL mid_queue_empty: got %h want 0", gnt); end
    next_cycle();
    #1;
    n_checks++; if (gnt !== bit_of(2)) begin n_fail++; $display("FAIL mid_regrant: got %h want %h", gnt, bit_of(2)); end
    req = '0;
  endtask

`ifdef WORMHOLE_LOCK_TIMEOUT_EN
  // Owner idles after its head flit: abort pulse on the 65th idle cycle, lock released
  task automatic test_lock_timeout();
    int abort_at;
    do_reset();
    req = bit_of(3); req_tail = '0;
    next_cycle(); next_cycle(); next_cycle();
    req = '0;
    abort_at = -1;
    for (int c = 0; c < 100 && abort_at < 0; c++) begin
      #1;
      if (lock_abort) abort_at = c;
      next_cycle();
    end
    n_checks++; if (abort_at !== 64) begin n_fail++; $display("FAIL timeout_cycle: got %0d want 64", abort_at); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL timeout_busy: got %b want 0", busy); end
    n_checks++; if (lock_abort !== 1'b0) begin n_fail++; $display("FAIL timeout_pulse: got %b want 0", lock_abort); end
  endtask
`else
  // Without the timeout, an idle owner keeps the lock indefinitely
  task automatic test_lock_hold();
    do_reset();
    req = bit_of(3); req_tail = '0;
    next_cycle(); next_cycle(); next_cycle();
    req = bit_of(11);
    for (int c = 0; c < 80; c++) next_cycle();
    #1;
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL hold_busy: got %b want 1", busy); end
    n_checks++; if (gnt !== '0) begin n_fail++; $display("FAIL hold_gnt: got %h want 0", gnt); end
    n_checks++; if (gnt_idx !== 5'd3) begin n_fail++; $display("FAIL hold_idx: got %0d want 3", gnt_idx); end
    req = '0;
  endtask
`endif

  initial begin
    test_reset();
    test_single_packet();
    test_fcfs();
    test_credit_stall();
    test_simultaneous();
    test_stale_entry();
    test_reset_mid_packet();
`ifdef WORMHOLE_LOCK_TIMEOUT_EN
    test_lock_timeout();
`else
    test_lock_hold();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
